rs_dec_sym_buf: RTL and testbench
=================================

Name: rs_dec_sym_buf

Overview:
- Received-codeword delay buffer for the RS decoder, placed directly upstream of the error-correction stage.
- Stores each incoming N_NUM-symbol block while syndrome, key-equation, Chien and Forney processing run.
- On the decoder's per-block start pulse, replays the oldest stored block as symb_with_err with a 1..N_NUM symb_cnt, aligned so the corrector's latched error locations/values are valid when symbol 1 arrives.

Parameters:
- SYM_BW, 8: symbol width in bits.
- N_NUM, 255: symbols per codeword (N_NUM < 2^SYM_BW).
- NBANK, 4: number of block banks; power of 2, >= 2.
- RD_LAT, 3: cycles from rd_start sample edge to symb_cnt==1; >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- symb_in_val  in  1  input symbol strobe.
- symb_in  in  SYM_BW  received symbol; block symbols arrive in order, first symbol first.
- rd_start  in  1  one-cycle pulse: errors for the oldest block are ready; same pulse that drives the corrector's start.
- symb_cnt  out  SYM_BW  replay index 1..N_NUM, 0 when idle.
- symb_with_err  out  SYM_BW  replayed received symbol, 0 when idle.
- blk_avail  out  1  at least one complete block is stored and not yet replayed.
- ovf  out  1  one-cycle pulse: a block was dropped because all banks were full.
- unf  out  1  one-cycle pulse: rd_start rejected (no block stored, or replay already in progress).

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0; wr_idx=0, wr_bank=0, rd_bank=0, blk_cnt=0, drop=0, FSM=IDLE. RAM contents are don't-care. Reset mid-block or mid-replay discards everything.
- Write side, per symb_in_val cycle:
  - If wr_idx==0, latch drop = (blk_cnt==NBANK). When drop is set, pulse ovf that cycle.
  - If !drop, write symb_in to RAM address {wr_bank, wr_idx}.
  - wr_idx increments; at wr_idx==N_NUM-1 it wraps to 0.
  - On the wrap, if !drop: wr_bank += 1 (mod NBANK) and blk_cnt increments. A dropped block leaves wr_bank and blk_cnt unchanged.
  - Gaps in symb_in_val are allowed; the partial block is held.
- blk_cnt, width clog2(NBANK+1):
  - Counts complete blocks, including the one currently being replayed.
  - Decrements when the last symbol (symb_cnt==N_NUM) is emitted.
  - Write-complete and read-complete in the same cycle leave blk_cnt unchanged.
  - blk_avail = (blk_cnt != 0) && (FSM == IDLE).
- Read FSM:
  - IDLE: on rd_start with blk_cnt!=0, load wait counter = RD_LAT-2 and go to WAIT. On rd_start with blk_cnt==0, pulse unf and stay in IDLE.
  - WAIT: decrement the counter. At 0, issue RAM read {rd_bank, 0} and go to READ.
  - READ: issue reads at rd_idx 1..N_NUM-1, one per cycle. The RAM has one-cycle registered read.
  - Output registers present symb_cnt=k and symb_with_err=RAM[{rd_bank,k-1}] for k=1..N_NUM on consecutive cycles, with the first at cycle T+RD_LAT (rd_start sampled at edge T).
  - After symb_cnt==N_NUM: rd_bank += 1 (mod NBANK), blk_cnt decrements, return to IDLE. The next cycle shows symb_cnt=0 and symb_with_err=0.
  - rd_start while in WAIT or READ: pulse unf, ignore the request, and continue the replay undisturbed.
- Back-to-back: rd_start in the cycle after the final symb_cnt==N_NUM is accepted if blk_cnt!=0, giving a minimum gap of RD_LAT idle cycles between blocks.
- Overwrite protection: the bank being replayed still counts in blk_cnt, so the writer can never overwrite it.
- Width rules: wr_idx and rd_idx are SYM_BW bits. Bank pointers are log2(NBANK) bits and wrap naturally. RAM depth is NBANK*2^SYM_BW.

Decomposition:
- Shared package holds: SYM_BW/N_NUM/R_BW constants already used decoder-wide, the read-FSM state enum (IDLE, WAIT, READ), and a clog2 function.
- One natural sub-module: rs_sdp_ram, a simple dual-port RAM with one write port and one read port, one-cycle registered read, parameterised width/depth, no reset on contents.

Test Plan:
- Single block: write symbols 1..255 contiguously; blk_avail=1 after the last write. rd_start at cycle T gives symb_cnt=1, symb_with_err=0x01 at T+3, then symb_cnt=255, symb_with_err=0xFF at T+257, then 0/0 at T+258; blk_avail=0.
- Fill and overflow: write 5 blocks (NBANK=4) with no reads. ovf pulses exactly once, at the first symbol of block 5. blk_cnt=4. Four replays return blocks 1..4 in order; block 5 is absent.
- Underflow/busy: rd_start with an empty buffer gives unf=1 for one cycle and symb_cnt stays 0. A second rd_start at replay symbol 100 gives unf=1 and the replay continues to 255 unchanged.
- Concurrent write/read: stream block 2 while block 1 replays, with the last write and symb_cnt==255 in the same cycle. blk_cnt stays 1 and block 2 replays intact.
- Gapped input: symb_in_val duty 50% random; the replayed data matches the written data exactly and symb_cnt is contiguous 1..255.
- Reset mid-replay: assert rst at symbol 50. All outputs are 0 within the cycle, blk_avail=0, and a new block written after reset replays correctly from bank 0.

Source files
------------

// File: rtl/rs_dec_sym_buf_pkg.sv
// Shared RS decoder definitions.
// Holds the decoder-wide symbol/codeword constants, the symbol-buffer read FSM
// state type and a constant-evaluable ceil(log2) helper.
package rs_dec_sym_buf_pkg;

    // Symbol width in bits.
    localparam int unsigned SYM_BW = 8;
    // Symbols per codeword; must be below 2**SYM_BW.
    localparam int unsigned N_NUM  = 255;
    // Width of the redundancy/error-count index used by the key-equation and Chien stages.
    localparam int unsigned R_BW   = 5;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRead
    } rd_state_e;

    // ceil(log2(val)); returns 0 for val <= 1.
    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(val)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, one-cycle registered read.
// Contents are not reset.
// Ports:
//   clk      clock
//   wr_en    write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read enable; rd_data updates on the next edge
//   rd_addr  read address
//   rd_data  registered read data
module rs_sdp_ram #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_BW = rs_dec_sym_buf_pkg::clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_BW-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    input  logic [ADDR_BW-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rs_dec_sym_buf.sv
// Received-codeword delay buffer for the RS decoder.
// Stores incoming N_NUM-symbol blocks in NBANK banks and, on each rd_start,
// replays the oldest stored block with a 1..N_NUM symbol index so it lines up
// with the corrector's latched error locations/values.
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-high
//   symb_in_val    input symbol strobe
//   symb_in        received symbol (block symbols in order)
//   rd_start       one-cycle pulse: errors for the oldest block are ready
//   symb_cnt       replay index 1..N_NUM, 0 when idle
//   symb_with_err  replayed received symbol, 0 when idle
//   blk_avail      a complete, not yet replayed block is stored and reader is idle
//   ovf            one-cycle pulse: incoming block dropped, all banks full
//   unf            one-cycle pulse: rd_start rejected (empty or busy)
module rs_dec_sym_buf #(
    parameter int unsigned SYM_BW = rs_dec_sym_buf_pkg::SYM_BW,
    parameter int unsigned N_NUM  = rs_dec_sym_buf_pkg::N_NUM,
    parameter int unsigned NBANK  = 4,
    parameter int unsigned RD_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              symb_in_val,
    input  logic [SYM_BW-1:0] symb_in,
    input  logic              rd_start,
    output logic [SYM_BW-1:0] symb_cnt,
    output logic [SYM_BW-1:0] symb_with_err,
    output logic              blk_avail,
    output logic              ovf,
    output logic              unf
);

    import rs_dec_sym_buf_pkg::*;

    localparam int unsigned BANK_BW = clog2(NBANK);
    localparam int unsigned CNT_BW  = clog2(NBANK + 1);
    localparam int unsigned WAIT_BW = (RD_LAT > 2) ? clog2(RD_LAT - 1) : 1;
    localparam int unsigned ADDR_BW = BANK_BW + SYM_BW;
    localparam int unsigned DEPTH   = NBANK << SYM_BW;

    localparam logic [SYM_BW-1:0]  LAST_IDX  = SYM_BW'(N_NUM - 1);
    localparam logic [SYM_BW-1:0]  NUM_SYM   = SYM_BW'(N_NUM);
    localparam logic [CNT_BW-1:0]  FULL_CNT  = CNT_BW'(NBANK);
    localparam logic [WAIT_BW-1:0] WAIT_INIT = WAIT_BW'(RD_LAT - 2);

    // Write side
    logic [SYM_BW-1:0]  wr_idx_q;
    logic [BANK_BW-1:0] wr_bank_q;
    logic               drop_q;
    logic               wr_drop;
    logic               wr_wrap;
    logic               blk_inc;
    logic               blk_full;

    // Block accounting
    logic [CNT_BW-1:0]  blk_cnt_q;
    logic               blk_dec;

    // Read side
    rd_state_e          state_q, state_d;
    logic [WAIT_BW-1:0] wait_q, wait_d;
    logic [SYM_BW-1:0]  rd_idx_q, rd_idx_d;
    logic [BANK_BW-1:0] rd_bank_q;
    logic               ram_rd_en;
    logic [SYM_BW-1:0]  ram_rd_idx;
    logic [SYM_BW-1:0]  ram_rd_data;
    logic               ram_vld_q;
    logic [SYM_BW-1:0]  ram_idx_q;
    logic               rd_done;

    // Output registers
    logic [SYM_BW-1:0]  symb_cnt_q;
    logic [SYM_BW-1:0]  symb_with_err_q;
    logic               ovf_q;
    logic               unf_q;

    assign blk_full = (blk_cnt_q == FULL_CNT);
    // The drop decision is taken on a block's first symbol and held for the rest of it.
    assign wr_drop  = (wr_idx_q == '0) ? blk_full : drop_q;
    assign wr_wrap  = symb_in_val && (wr_idx_q == LAST_IDX);
    assign blk_inc  = wr_wrap && !wr_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q  <= '0;
            wr_bank_q <= '0;
            drop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ovf_q <= symb_in_val && (wr_idx_q == '0) && blk_full;
            if (symb_in_val) begin
                drop_q   <= wr_drop;
                wr_idx_q <= wr_wrap ? '0 : wr_idx_q + 1'b1;
                if (blk_inc) begin
                    wr_bank_q <= wr_bank_q + 1'b1;
                end
            end
        end
    end

    // The bank under replay stays counted until its last symbol leaves, which keeps the
    // writer off it.
    assign blk_dec = rd_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else if (blk_inc && !blk_dec) begin
            blk_cnt_q <= blk_cnt_q + 1'b1;
        end else if (!blk_inc && blk_dec) begin
            blk_cnt_q <= blk_cnt_q - 1'b1;
        end
    end

    // Read FSM: WAIT pads the latency so symbol 1 appears RD_LAT cycles after rd_start;
    // the RAM stage and the output register account for the last two cycles.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        rd_idx_d   = rd_idx_q;
        ram_rd_en  = 1'b0;
        ram_rd_idx = rd_idx_q;
        unique case (state_q)
            StIdle: begin
                if (rd_start && (blk_cnt_q != '0)) begin
                    wait_d  = WAIT_INIT;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (wait_q == '0) begin
                    ram_rd_en  = 1'b1;
                    ram_rd_idx = '0;
                    rd_idx_d   = SYM_BW'(1);
                    state_d    = StRead;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            StRead: begin
                // After the last read, hold here until that symbol reaches the output.
                if (rd_idx_q != NUM_SYM) begin
                    ram_rd_en = 1'b1;
                    rd_idx_d  = rd_idx_q + 1'b1;
                end
                if (rd_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            rd_idx_q  <= '0;
            rd_bank_q <= '0;
            unf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            rd_idx_q <= rd_idx_d;
            unf_q    <= rd_start && ((state_q != StIdle) || (blk_cnt_q == '0));
            if (rd_done) begin
                rd_bank_q <= rd_bank_q + 1'b1;
            end
        end
    end

    rs_sdp_ram #(
        .WIDTH  (SYM_BW),
        .DEPTH  (DEPTH),
        .ADDR_BW(ADDR_BW)
    ) u_ram (
        .clk    (clk),
        .wr_en  (symb_in_val && !wr_drop),
        .wr_addr({wr_bank_q, wr_idx_q}),
        .wr_data(symb_in),
        .rd_en  (ram_rd_en),
        .rd_addr({rd_bank_q, ram_rd_idx}),
        .rd_data(ram_rd_data)
    );

    // Tracks which symbol the RAM is presenting; ram_rd_data itself is never reset.
    assign rd_done = ram_vld_q && (ram_idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_vld_q       <= 1'b0;
            ram_idx_q       <= '0;
            symb_cnt_q      <= '0;
            symb_with_err_q <= '0;
        end else begin
            ram_vld_q       <= ram_rd_en;
            ram_idx_q       <= ram_rd_idx;
            symb_cnt_q      <= ram_vld_q ? ram_idx_q + 1'b1 : '0;
            symb_with_err_q <= ram_vld_q ? ram_rd_data : '0;
        end
    end

    assign symb_cnt      = symb_cnt_q;
    assign symb_with_err = symb_with_err_q;
    assign blk_avail     = (blk_cnt_q != '0) && (state_q == StIdle);
    assign ovf           = ovf_q;
    assign unf           = unf_q;

endmodule

// File: tb/tb_rs_dec_sym_buf.sv
// Self-checking bench for rs_dec_sym_buf: table-driven single-block round trips plus
// hand-written sequences for overflow, underflow/busy, back-to-back, concurrent
// write/read and reset during replay. A byte-level model FIFO feeds a scoreboard
// queue that the output monitor drains.
module tb_rs_dec_sym_buf;

    import rs_dec_sym_buf_pkg::*;

    localparam int unsigned NB  = 4;
    localparam int unsigned LAT = 3;

    logic              clk;
    logic              rst;
    logic              symb_in_val;
    logic [SYM_BW-1:0] symb_in;
    logic              rd_start;
    logic [SYM_BW-1:0] symb_cnt;
    logic [SYM_BW-1:0] symb_with_err;
    logic              blk_avail;
    logic              ovf;
    logic              unf;

    rs_dec_sym_buf #(
        .SYM_BW(SYM_BW),
        .N_NUM (N_NUM),
        .NBANK (NB),
        .RD_LAT(LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .symb_in_val  (symb_in_val),
        .symb_in      (symb_in),
        .rd_start     (rd_start),
        .symb_cnt     (symb_cnt),
        .symb_with_err(symb_with_err),
        .blk_avail    (blk_avail),
        .ovf          (ovf),
        .unf          (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Model state
    logic [SYM_BW-1:0] model_fifo[$];
    logic [SYM_BW-1:0] sb_q[$];
    int                model_cnt;
    bit                busy_m;
    int unsigned       exp_idx;
    int unsigned       first_cyc, done_cyc, t_start, ovf_seen;
    logic [SYM_BW-1:0] first_seen, last_seen, mon_exp;

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        bit         gapped;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Output monitor / scoreboard drain
    always @(negedge clk) begin
        if (!rst) begin
            if (ovf) ovf_seen++;
            if (symb_cnt != '0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_symb", symb_cnt, 0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("symb_cnt", symb_cnt, exp_idx);
                    check("symb_data", symb_with_err, mon_exp);
                    if (exp_idx == 1) begin
                        first_seen = symb_with_err;
                        first_cyc  = cyc;
                    end
                    if (exp_idx == N_NUM) begin
                        last_seen = symb_with_err;
                        done_cyc  = cyc;
                        busy_m    = 1'b0;
                        model_cnt--;
                    end
                    exp_idx++;
                end
            end else begin
                check("idle_data", symb_with_err, 0);
                if (exp_idx > 1 && sb_q.size() != 0) check("symb_gap", symb_cnt, exp_idx);
            end
        end
    end

    task automatic write_block(input logic [7:0] base, input logic [7:0] step, input bit gapped);
        logic [SYM_BW-1:0] v;
        logic [SYM_BW-1:0] tmp[$];
        bit                dropped;
        v       = base;
        dropped = (model_cnt == NB);
        for (int k = 0; k < N_NUM; k++) begin
            if (gapped && $urandom_range(0, 1) == 1) begin
                symb_in_val = 1'b0;
                @(posedge clk);
                #1;
            end
            symb_in_val = 1'b1;
            symb_in     = v;
            tmp.push_back(v);
            @(posedge clk);
            #1;
            if (k == 0) check("ovf_at_first_sym", ovf, dropped);
            v = v + step;
        end
        symb_in_val = 1'b0;
        if (!dropped) begin
            while (tmp.size() != 0) model_fifo.push_back(tmp.pop_front());
            model_cnt++;
        end
    endtask

    task automatic start_read();
        bit acc;
        acc = !busy_m && (model_cnt > 0);
        if (acc) begin
            for (int k = 0; k < N_NUM; k++) sb_q.push_back(model_fifo.pop_front());
            exp_idx = 1;
            busy_m  = 1'b1;
        end
        rd_start = 1'b1;
        @(posedge clk);
        #1;
        rd_start = 1'b0;
        t_start  = cyc;
        @(negedge clk);
        check("unf", unf, !acc);
    endtask

    task automatic wait_done();
        int unsigned n;
        n = 0;
        while (busy_m && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("replay_done", busy_m, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        symb_in_val = 1'b0;
        symb_in     = '0;
        rd_start    = 1'b0;
        model_cnt   = 0;
        busy_m      = 1'b0;
        exp_idx     = 0;
        ovf_seen    = 0;

        vecs[0] = '{8'h01, 8'h01, 1'b0, 8'h01, 8'hFF};
        vecs[1] = '{8'hA5, 8'h00, 1'b0, 8'hA5, 8'hA5};
        vecs[2] = '{8'h00, 8'h03, 1'b1, 8'h00, 8'hFA};
        vecs[3] = '{8'h80, 8'hFF, 1'b1, 8'h80, 8'h82};
        vecs[4] = '{8'h10, 8'h02, 1'b0, 8'h10, 8'h0C};

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_symb_cnt", symb_cnt, 0);
        check("rst_symb_data", symb_with_err, 0);
        check("rst_blk_avail", blk_avail, 0);
        check("rst_ovf", ovf, 0);
        check("rst_unf", unf, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Empty buffer: rd_start rejected, nothing replayed.
        start_read();
        @(negedge clk);
        check("unf_one_cycle", unf, 0);
        repeat (4) begin
            @(negedge clk);
            check("empty_no_output", symb_cnt, 0);
        end

        // Table-driven single-block round trips.
        foreach (vecs[i]) begin
            write_block(vecs[i].base, vecs[i].step, vecs[i].gapped);
            check("avail_after_write", blk_avail, 1);
            start_read();
            wait_done();
            check("first_sym", first_seen, vecs[i].exp_first);
            check("last_sym", last_seen, vecs[i].exp_last);
            check("latency", first_cyc, t_start + LAT);
            check("span", done_cyc - first_cyc, N_NUM - 1);
            @(negedge clk);
            check("idle_after_cnt", symb_cnt, 0);
            check("avail_after_read", blk_avail, 0);
        end

        // Busy: rd_start during replay is rejected and replay continues.
        write_block(8'h33, 8'h05, 1'b0);
        start_read();
        for (int n = 0; n < 400 && exp_idx <= 100; n++) begin
            @(negedge clk);
            #1;
        end
        start_read();
        wait_done();
        check("busy_last_sym", last_seen, 8'h29);
        check("busy_span", done_cyc - first_cyc, N_NUM - 1);
        @(negedge clk);
        check("busy_avail_after", blk_avail, 0);

        // Fill and overflow, then back-to-back replays of the four kept blocks.
        ovf_seen = 0;
        for (int b = 1; b <= 5; b++) write_block(8'(b * 16), 8'h01, 1'b0);
        check("ovf_count", ovf_seen, 1);
        check("avail_full", blk_avail, 1);
        start_read();
        for (int b = 1; b <= 4; b++) begin
            wait_done();
            check("fill_first_sym", first_seen, 8'(b * 16));
            check("fill_latency", first_cyc, t_start + LAT);
            if (b < 4) start_read();
        end
        start_read();  // block 5 was dropped
        check("fill_empty_avail", blk_avail, 0);

        // Concurrent: last write of block 2 lands on the edge that emits symbol 255.
        write_block(8'h40, 8'h01, 1'b0);
        start_read();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        write_block(8'h90, 8'h03, 1'b0);
        wait_done();
        check("concur_align", done_cyc, t_start + LAT + N_NUM - 1);
        check("concur_last_blk1", last_seen, 8'h3E);
        check("concur_avail", blk_avail, 1);
        start_read();
        wait_done();
        check("concur_first_blk2", first_seen, 8'h90);
        check("concur_last_blk2", last_seen, 8'h8A);
        start_read();  // exactly one block was pending

        // Reset at replay symbol 50.
        write_block(8'h77, 8'h01, 1'b0);
        start_read();
        for (int n = 0; n < 400 && exp_idx <= 50; n++) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_symb_cnt", symb_cnt, 0);
        check("mid_rst_symb_data", symb_with_err, 0);
        check("mid_rst_blk_avail", blk_avail, 0);
        check("mid_rst_unf", unf, 0);
        sb_q.delete();
        model_fifo.delete();
        model_cnt = 0;
        busy_m    = 1'b0;
        exp_idx   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_avail", blk_avail, 0);
        write_block(8'hC0, 8'h07, 1'b0);
        start_read();
        wait_done();
        check("post_rst_first", first_seen, 8'hC0);
        check("post_rst_last", last_seen, 8'hB2);
        check("post_rst_latency", first_cyc, t_start + LAT);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
